wb_rr_arbiter: RTL and testbench

//  Multi-channel write-back stage. Collects results from NUM_CH producers (ALU, LSU, PC+4 link, ...),

---
 rtl/wb_rr_arbiter_pkg.sv | 21 ++
 rtl/wb_rr_arbiter_if.sv | 42 ++++
 rtl/wb_chan_fifo.sv | 64 ++++++
 rtl/wb_rr_arbiter.sv | 97 +++++++++
 tb/tb_wb_rr_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types for the multi-channel write-back arbiter.
// Holds the result entry layout and RF address helpers.
package wb_rr_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef logic [RA_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam reg_addr_t RF_ZERO_ADDR = '0;

    function automatic logic is_zero_rd(reg_addr_t rd);
        return rd == RF_ZERO_ADDR;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Producer-side and register-file-side signals of the write-back arbiter.
// master drives producer results; slave is the arbiter.
interface wb_rr_arbiter_if #(
    parameter int NUM_CH = 3
);
    import wb_rr_arbiter_pkg::*;

    logic                   flush_i;
    logic [NUM_CH-1:0]      ch_valid_i;
    logic [NUM_CH-1:0]      ch_ready_o;
    logic [NUM_CH*RA_W-1:0] ch_rd_i;
    logic [NUM_CH*XLEN-1:0] ch_data_i;
    logic                   rf_we_o;
    reg_addr_t              rf_rd_o;
    logic [XLEN-1:0]        rf_data_o;
    logic                   busy_o;

    modport master (
        output flush_i,
        output ch_valid_i,
        output ch_rd_i,
        output ch_data_i,
        input  ch_ready_o,
        input  rf_we_o,
        input  rf_rd_o,
        input  rf_data_o,
        input  busy_o
    );

    modport slave (
        input  flush_i,
        input  ch_valid_i,
        input  ch_rd_i,
        input  ch_data_i,
        output ch_ready_o,
        output rf_we_o,
        output rf_rd_o,
        output rf_data_o,
        output busy_o
    );

endinterface

// File: rtl/wb_chan_fifo.sv
// Per-channel result FIFO: DEPTH entries, async reset, sync clear.
// Count carries one extra bit so full and empty are distinct.
module wb_chan_fifo
    import wb_rr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clear,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Write-back stage: per-channel result FIFOs round-robin arbitrated
// onto the single register-file write port through a registered output.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 2
) (
    input logic            clk,
    input logic            rst_n,
    wb_rr_arbiter_if.slave bus
);

    localparam int PW = $clog2(NUM_CH);

    wb_entry_t         head [NUM_CH];
    wb_entry_t         sel;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] grant;
    logic [PW-1:0]     gidx;
    logic              any_req;
    logic [PW-1:0]     rr_ptr;
    logic              rf_we;
    reg_addr_t         rf_rd;
    logic [XLEN-1:0]   rf_data;

    assign bus.ch_ready_o = ~full & {NUM_CH{~bus.flush_i}};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        wb_entry_t din;

        assign din.rd   = bus.ch_rd_i[c*RA_W +: RA_W];
        assign din.data = bus.ch_data_i[c*XLEN +: XLEN];
        // x0 results are consumed here and never reach the FIFO.
        assign push[c]  = bus.ch_valid_i[c] & bus.ch_ready_o[c]
                        & ~is_zero_rd(din.rd);

        wb_chan_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (bus.flush_i),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (din),
            .full  (full[c]),
            .empty (empty[c]),
            .head  (head[c])
        );
    end

    // First non-empty channel at or after the rr pointer wins.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any_req && !empty[(int'(rr_ptr) + i) % NUM_CH]) begin
                any_req = 1'b1;
                grant[(int'(rr_ptr) + i) % NUM_CH] = 1'b1;
                gidx = PW'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
        sel = head[gidx];
    end

    assign pop = grant & {NUM_CH{~bus.flush_i}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else if (bus.flush_i) begin
            rr_ptr  <= '0;
            rf_we   <= 1'b0;
        end else if (any_req) begin
            rf_we   <= 1'b1;
            rf_rd   <= sel.rd;
            rf_data <= sel.data;
            rr_ptr  <= (gidx == PW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    assign bus.rf_we_o   = rf_we;
    assign bus.rf_rd_o   = rf_rd;
    assign bus.rf_data_o = rf_data;
    assign bus.busy_o    = (|(~empty)) | rf_we;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomised scoreboard bench for wb_rr_arbiter with a queue-based
// reference model of the buffering and round-robin rules.
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    localparam int NCH = 3;
    localparam int DEP = 2;

    logic clk;
    logic rst_n;

    wb_rr_arbiter_if #(.NUM_CH(NCH)) bus ();

    wb_rr_arbiter #(
        .NUM_CH (NCH),
        .DEPTH  (DEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: one queue per channel, rr pointer as an integer.
    wb_entry_t mq [NCH][$];
    wb_entry_t expq [$];
    int        mptr = 0;
    logic      mwe  = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            expq.delete();
            mptr = 0;
            mwe  = 1'b0;
        end else if (bus.flush_i) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            mptr = 0;
            mwe  = 1'b0;
        end else begin
            bit acc [NCH];
            int g;
            g = -1;
            for (int c = 0; c < NCH; c++)
                acc[c] = bus.ch_valid_i[c] && (mq[c].size() < DEP);
            for (int i = 0; i < NCH; i++)
                if (g < 0 && mq[(mptr + i) % NCH].size() > 0)
                    g = (mptr + i) % NCH;
            if (g >= 0) begin
                expq.push_back(mq[g].pop_front());
                mptr = (g + 1) % NCH;
                mwe  = 1'b1;
            end else begin
                mwe  = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                wb_entry_t e;
                e.rd   = bus.ch_rd_i[c*RA_W +: RA_W];
                e.data = bus.ch_data_i[c*XLEN +: XLEN];
                if (acc[c] && e.rd != 0) mq[c].push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs with the model away from the edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            logic [NCH-1:0] er;
            logic           eb;
            eb = mwe;
            for (int c = 0; c < NCH; c++) begin
                er[c] = !bus.flush_i && (mq[c].size() < DEP);
                if (mq[c].size() > 0) eb = 1'b1;
            end
            chk("ready", 64'(bus.ch_ready_o), 64'(er));
            chk("busy", 64'(bus.busy_o), 64'(eb));
            chk("we", 64'(bus.rf_we_o), 64'(mwe));
            if (bus.rf_we_o) begin
                if (expq.size() == 0) begin
                    chk("sb_extra_write", 64'(1), 64'(0));
                end else begin
                    wb_entry_t e;
                    e = expq.pop_front();
                    chk("rd", 64'(bus.rf_rd_o), 64'(e.rd));
                    chk("data", 64'(bus.rf_data_o), 64'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ch(int c, logic v, logic [4:0] rd,
                          logic [31:0] d);
        bus.ch_valid_i[c]              = v;
        bus.ch_rd_i[c*RA_W +: RA_W]    = rd;
        bus.ch_data_i[c*XLEN +: XLEN]  = d;
    endtask

    task automatic idle();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 5'd0, 32'd0);
        bus.flush_i = 1'b0;
    endtask

    int tag = 1;

    task automatic all_valid(int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < NCH; c++) begin
                set_ch(c, 1'b1, 5'(c*8 + (tag % 7) + 1),
                       32'(tag * 16 + c));
                tag++;
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 64'(bus.rf_we_o), 64'(0));
        chk("rst_rd", 64'(bus.rf_rd_o), 64'(0));
        chk("rst_data", 64'(bus.rf_data_o), 64'(0));
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", 64'(bus.ch_ready_o), 64'(3'b111));

        // single beat latency
        set_ch(1, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        idle();
        chk("t2_we_k", 64'(bus.rf_we_o), 64'(0));
        step();
        chk("t2_we_k1", 64'(bus.rf_we_o), 64'(1));
        chk("t2_rd", 64'(bus.rf_rd_o), 64'(5));
        chk("t2_data", 64'(bus.rf_data_o), 64'(32'hDEADBEEF));
        step();
        chk("t2_we_k2", 64'(bus.rf_we_o), 64'(0));

        // contention, full boundary
        all_valid(9);
        idle();
        repeat (8) step();

        // x0 drop
        set_ch(0, 1'b1, 5'd0, 32'd1);
        step();
        idle();
        step();
        chk("x0_we", 64'(bus.rf_we_o), 64'(0));
        chk("x0_busy", 64'(bus.busy_o), 64'(0));

        // flush
        all_valid(2);
        idle();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("fl_we", 64'(bus.rf_we_o), 64'(0));
        chk("fl_busy", 64'(bus.busy_o), 64'(0));
        step();
        chk("fl_we2", 64'(bus.rf_we_o), 64'(0));
        all_valid(2);
        idle();
        repeat (6) step();

        // reset mid-stream
        all_valid(2);
        idle();
        rst_n = 1'b0;
        #1;
        chk("mrst_we", 64'(bus.rf_we_o), 64'(0));
        chk("mrst_busy", 64'(bus.busy_o), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mrst_we2", 64'(bus.rf_we_o), 64'(0));
        all_valid(3);
        idle();
        repeat (8) step();

        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                logic [4:0] r;
                r = ($urandom_range(0, 7) == 0) ? 5'd0
                  : 5'($urandom_range(1, 31));
                set_ch(c, 1'($urandom_range(0, 3) != 0), r, $urandom);
            end
            bus.flush_i = ($urandom_range(0, 49) == 0);
            if (i == 700) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        idle();
        repeat (10) step();
        chk("drain_empty", 64'(expq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
